// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op type and op encodings for the gate pipe
// Contents:
//   op_t  3-bit bitwise operation select used on the request side and on f_op
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_t;

endpackage

// File: rtl/gate_pipe_if.sv
// rtl/gate_pipe_if.sv - request/result handshake bundle for the gate pipe
// Signals:
//   in_valid/in_ready    request handshake; op, a, b travel with it
//   out_valid/out_ready  result handshake; f, f_op, f_zero describe the head entry
//   count                result buffer occupancy
// Modports:
//   master  producer/consumer side (drives request and out_ready)
//   slave   gate_pipe side
interface gate_pipe_if
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  op_t              f_op;
  logic             f_zero;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, f, f_op, f_zero, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, f, f_op, f_zero, count
  );

endinterface

// File: rtl/gate_fifo.sv
// rtl/gate_fifo.sv - DEPTH-entry result buffer with wrapping pointers
// Ports:
//   clk, rst     clock and synchronous active-high reset (pointers/count only)
//   wr_en_i      write wr_data_i at the tail (ignored when full)
//   rd_en_i      drop the head entry (ignored when empty)
//   rd_data_o    head entry, read combinationally from storage
//   count_o      occupancy; full_o / empty_o derived from it
module gate_fifo #(
  parameter int  W     = 12,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i && !full_o;
  assign rd_ok   = rd_en_i && !empty_o;

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; stale entries are unreachable
  // once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/gate_pipe.sv
// rtl/gate_pipe.sv - bitwise gate operation with buffered, in-order results
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       gate_pipe_if slave: request (in_valid/in_ready/op/a/b),
//             head result (out_valid/out_ready/f/f_op/f_zero), occupancy (count)
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  gate_pipe_if.slave  bus
);

  localparam int EW = WIDTH + 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;
  logic [CW-1:0]    count;

  always_comb begin
    result = '0;
    case (bus.op)
      OP_AND:  result = bus.a & bus.b;
      OP_OR:   result = bus.a | bus.b;
      OP_XOR:  result = bus.a ^ bus.b;
      OP_XNOR: result = ~(bus.a ^ bus.b);
      OP_NAND: result = ~(bus.a & bus.b);
      OP_NOR:  result = ~(bus.a | bus.b);
      OP_NOTA: result = ~bus.a;
      OP_PASS: result = bus.a;
      default: result = '0;
    endcase
  end

  assign result_zero = ~|result;

  // in_ready depends on occupancy only: a full buffer refuses a push even
  // when the head is being popped in the same cycle.
  assign push     = bus.in_valid && !full;
  assign pop      = bus.out_ready && !empty;
  assign wr_entry = {bus.op, result_zero, result};

  gate_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.f         = rd_entry[WIDTH-1:0];
  assign bus.f_zero    = rd_entry[WIDTH];
  assign bus.f_op      = op_t'(rd_entry[WIDTH+3:WIDTH+1]);
  assign bus.count     = count;

endmodule

// File: tb/tb_gate_pipe.sv
// tb/tb_gate_pipe.sv - directed self-checking bench for gate_pipe (WIDTH=8, DEPTH=4)
module tb_gate_pipe;
  import gate_pkg::*;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  gate_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

  gate_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are changed and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input op_t o, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
  endtask

  task automatic head(input string tag, input logic [7:0] ef, input op_t eo, input logic [2:0] ec);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_f"},     64'(bus.f),         64'(ef));
    check({tag, "_op"},    64'(bus.f_op),      64'(eo));
    check({tag, "_zero"},  64'(bus.f_zero),    64'(ef == 8'h00));
    check({tag, "_count"}, 64'(bus.count),     64'(ec));
  endtask

  logic [7:0] exp_tab [8];

  initial begin
    vecs = 0;
    errs = 0;
    exp_tab[0] = 8'hC0; exp_tab[1] = 8'hFC; exp_tab[2] = 8'h3C; exp_tab[3] = 8'hC3;
    exp_tab[4] = 8'h3F; exp_tab[5] = 8'h03; exp_tab[6] = 8'h0F; exp_tab[7] = 8'hF0;
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    rst = 1'b1;

    // Scenario 1: reset held for two cycles
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_count",     64'(bus.count),     64'(0));

    // Scenario 2: op table with a=F0, b=CC
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, op_t'(3'(i)), 8'hF0, 8'hCC);
      step();
      drive(1'b0, OP_AND, 8'h00, 8'h00);
      head($sformatf("optab%0d", i), exp_tab[i], op_t'(3'(i)), 3'd1);
      step();
      check($sformatf("optab%0d_pop", i), 64'(bus.count), 64'(0));
    end

    // Scenario 3: fill to DEPTH, fifth request held, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_PASS, 8'(i + 1), 8'h00);
      step();
      check($sformatf("fill%0d_count", i), 64'(bus.count), 64'(i + 1));
    end
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    drive(1'b1, OP_PASS, 8'h05, 8'h00);
    step();
    check("held_count",    64'(bus.count),    64'(4));
    check("held_in_ready", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    head("drain1", 8'h01, OP_PASS, 3'd4);
    step();
    head("drain2", 8'h02, OP_PASS, 3'd3);
    check("drain2_in_ready", 64'(bus.in_ready), 64'(1));
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    head("drain3", 8'h03, OP_PASS, 3'd3);
    step();
    head("drain4", 8'h04, OP_PASS, 3'd2);
    step();
    head("drain5", 8'h05, OP_PASS, 3'd1);
    step();
    check("drain_empty", 64'(bus.out_valid), 64'(0));

    // Scenario 4: simultaneous accept and pop at count=2
    bus.out_ready = 1'b0;
    drive(1'b1, OP_PASS, 8'h11, 8'h00);
    step();
    drive(1'b1, OP_OR, 8'h22, 8'h00);
    step();
    check("sim_pre_count", 64'(bus.count), 64'(2));
    drive(1'b1, OP_NOR, 8'h33, 8'h00);
    bus.out_ready = 1'b1;
    head("sim_head0", 8'h11, OP_PASS, 3'd2);
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    head("sim_head1", 8'h22, OP_OR, 3'd2);
    step();
    head("sim_head2", 8'hCC, OP_NOR, 3'd1);
    step();
    check("sim_empty", 64'(bus.count), 64'(0));

    // Scenario 5: reset with three results buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_PASS, 8'(8'h44 + 8'(i * 17)), 8'h00);
      step();
    end
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    check("mid_count", 64'(bus.count), 64'(3));
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_PASS, 8'h99, 8'h00);
    step();
    rst = 1'b0;
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    check("mid_rst_count",     64'(bus.count),     64'(0));
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
    step();
    check("mid_idle_out_valid", 64'(bus.out_valid), 64'(0));
    drive(1'b1, OP_PASS, 8'h77, 8'h00);
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    head("mid_new", 8'h77, OP_PASS, 3'd1);
    step();
    check("mid_new_pop", 64'(bus.count), 64'(0));

    // Scenario 6: continuous accept/pop of AA^AA across pointer wraps
    bus.out_ready = 1'b1;
    drive(1'b1, OP_XOR, 8'hAA, 8'hAA);
    for (int i = 0; i < 10; i++) begin
      step();
      head($sformatf("wrap%0d", i), 8'h00, OP_XOR, 3'd1);
    end
    drive(1'b0, OP_AND, 8'h00, 8'h00);
    step();
    check("wrap_empty", 64'(bus.out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
